// File: rtl/audio_fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : audio_fir_mac
// Description : Runtime-programmable stereo FIR filter. One time-multiplexed
//               MAC per channel processes a frame per AUD_DACLRCK rising
//               edge; round-half-up, arithmetic shift, per-channel saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_fir_mac #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 8,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                  AUD_BCLK,
  input  logic                  rst,
  input  logic                  AUD_DACLRCK,
  input  logic [2*DATA_W-1:0]   audioIn,
  input  logic                  bypass,
  input  logic                  coef_we,
  input  logic [4:0]            coef_addr,
  input  logic [COEF_W-1:0]     coef_data,
  output logic [2*DATA_W-1:0]   audioOut,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  coef_rej
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 5;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [5:0]              TAPS_CNT = 6'(TAPS);
  localparam logic [COEF_W-1:0]       COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                       lrck_q;
  logic                       frame_edge;
  logic                       start, mac_en, out_en, coef_ok;
  logic [IDX_W-1:0]           idx;
  logic signed [DATA_W-1:0]   x_l [TAPS];
  logic signed [DATA_W-1:0]   x_r [TAPS];
  logic signed [COEF_W-1:0]   coef [TAPS];
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [PROD_W-1:0]   prod_l, prod_r;
  logic signed [DATA_W-1:0]   in_l, in_r;
  logic [DATA_W-1:0]          res_l, res_r;
  logic                       byp_q;
  logic [2*DATA_W-1:0]        raw_q;

  assign frame_edge = AUD_DACLRCK & ~lrck_q;
  assign busy       = (state != S_IDLE);
  assign in_l       = audioIn[2*DATA_W-1 -: DATA_W];
  assign in_r       = audioIn[DATA_W-1:0];

  // Both channels share the coefficient selected by idx.
  assign prod_l = PROD_W'(x_l[idx]) * PROD_W'(coef[idx]);
  assign prod_r = PROD_W'(x_r[idx]) * PROD_W'(coef[idx]);

  // Round half up, shift out the fractional bits, clamp to the sample range.
  function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = (a + RND) >>> FRAC_BITS;
    if (s > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (s < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return s[DATA_W-1:0];
  endfunction

  // Final rounded/saturated result for each channel.
  always_comb begin
    res_l = round_sat(acc_l);
    res_r = round_sat(acc_r);
  end

  // FSM state register.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    mac_en    = 1'b0;
    out_en    = 1'b0;
    coef_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_edge) begin
          start     = 1'b1;
          state_nxt = S_MAC;
        end else if (coef_we && ({1'b0, coef_addr} < TAPS_CNT)) begin
          coef_ok = 1'b1;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (idx == LAST_IDX) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_en    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame-strobe history and the one-cycle status pulses.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      lrck_q   <= 1'b0;
      overrun  <= 1'b0;
      coef_rej <= 1'b0;
    end else begin
      lrck_q   <= AUD_DACLRCK;
      overrun  <= frame_edge && (state != S_IDLE);
      coef_rej <= coef_we && !coef_ok;
    end
  end

  // Coefficient bank; resets to a near-identity response.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      coef[0] <= COEF_ONE;
    end else if (coef_ok) begin
      coef[coef_addr[IDX_W-1:0]] <= coef_data;
    end
  end

  // Delay lines shift only on accepted frames, bypassed or not.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_l[k] <= '0;
        x_r[k] <= '0;
      end
    end else if (start) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        x_l[k] <= x_l[k-1];
        x_r[k] <= x_r[k-1];
      end
      x_l[0] <= in_l;
      x_r[0] <= in_r;
    end
  end

  // Accumulators, tap index and the latched bypass/raw sample.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      acc_l <= '0;
      acc_r <= '0;
      idx   <= '0;
      byp_q <= 1'b0;
      raw_q <= '0;
    end else if (start) begin
      acc_l <= '0;
      acc_r <= '0;
      idx   <= '0;
      byp_q <= bypass;
      raw_q <= audioIn;
    end else if (mac_en) begin
      acc_l <= acc_l + ACC_W'(prod_l);
      acc_r <= acc_r + ACC_W'(prod_r);
      idx   <= idx + 1'b1;
    end
  end

  // Output register, updated once per accepted frame.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      audioOut  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_en;
      if (out_en) audioOut <= byp_q ? raw_q : {res_l, res_r};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_fir_mac
// Description : Directed self-checking bench for audio_fir_mac (TAPS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_fir_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrck;
  logic [31:0] audio_in;
  logic        bypass;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic [31:0] audio_out;
  logic        out_valid, busy, overrun, coef_rej;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_fir_mac #(
    .DATA_W(16), .TAPS(8), .COEF_W(16), .FRAC_BITS(15)
  ) dut (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck), .audioIn(audio_in),
    .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .audioOut(audio_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .coef_rej(coef_rej)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_coef(input string tag, input logic [4:0] a, input logic [15:0] d,
                            input logic exp_rej);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    check(tag, {31'b0, coef_rej}, {31'b0, exp_rej});
  endtask

  // One frame: edge, latency, value and single-pulse checks.
  task automatic frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                       input logic [31:0] exp);
    int n;
    @(negedge clk);
    audio_in = {l, r};
    lrck     = 1'b1;
    @(posedge clk); #1;
    lrck = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 32'd9);
    check({tag, "_out"}, audio_out, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b0; lrck = 1'b0; audio_in = '0; bypass = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out",     audio_out, 32'h0);
    check("rst_valid",   {31'b0, out_valid}, 32'd0);
    check("rst_busy",    {31'b0, busy}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_rej",     {31'b0, coef_rej}, 32'd0);
    rst = 1'b1;

    // Reset identity: {1000,-1000} passes through.
    frame("ident", 16'd1000, 16'hFC18, 32'h03E8_FC18);

    // Held-high strobe: exactly one frame.
    do_reset();
    @(negedge clk);
    audio_in = {16'd1000, 16'hFC18};
    lrck     = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    lrck = 1'b0;
    check("held_pulses", pulses, 32'd1);
    check("held_out", audio_out, 32'h03E8_FC18);

    // Impulse response with {8192,16384,8192}.
    do_reset();
    write_coef("imp_w0", 5'd0, 16'd8192, 1'b0);
    write_coef("imp_w1", 5'd1, 16'd16384, 1'b0);
    write_coef("imp_w2", 5'd2, 16'd8192, 1'b0);
    frame("imp0", 16'd16384, 16'd0, 32'h1000_0000);
    frame("imp1", 16'd0, 16'd0, 32'h2000_0000);
    frame("imp2", 16'd0, 16'd0, 32'h1000_0000);
    frame("imp3", 16'd0, 16'd0, 32'h0000_0000);

    // Saturation in both directions, no wrap.
    do_reset();
    write_coef("sat_w1", 5'd1, 16'd32767, 1'b0);
    frame("sat0", 16'h7FFF, 16'h8000, 32'h7FFE_8001);
    frame("sat1", 16'h7FFF, 16'h8000, 32'h7FFF_8000);

    // Overrun at E+3 and a rejected write during MAC.
    do_reset();
    write_coef("addr9", 5'd9, 16'd1234, 1'b1);
    @(negedge clk);
    audio_in = {16'd500, 16'd7};
    lrck     = 1'b1;
    @(posedge clk); #1;
    lrck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    lrck     = 1'b1;
    audio_in = {16'd9999, 16'd9999};
    @(posedge clk); #1;
    check("ovr_pulse", {31'b0, overrun}, 32'd1);
    lrck = 1'b0;
    coef_we = 1'b1; coef_addr = 5'd2; coef_data = 16'd32767;
    @(posedge clk); #1;
    coef_we = 1'b0;
    check("ovr_clear", {31'b0, overrun}, 32'd0);
    check("mac_rej", {31'b0, coef_rej}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovr_lat", n, 32'd5);
    check("ovr_out", audio_out, 32'h01F4_0007);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("ovr_single", pulses, 32'd0);
    write_coef("ovr_w0", 5'd0, 16'd0, 1'b0);
    write_coef("ovr_w1", 5'd1, 16'd32767, 1'b0);
    frame("ovr_hist", 16'd0, 16'd0, 32'h01F4_0007);
    frame("ovr_coef2", 16'd0, 16'd0, 32'h0000_0000);

    // Bypass, then filtered output from the shifted history.
    do_reset();
    write_coef("byp_w0", 5'd0, 16'd0, 1'b0);
    bypass = 1'b1;
    frame("byp", 16'd123, 16'hFE38, 32'h007B_FE38);
    bypass = 1'b0;
    write_coef("byp_w1", 5'd1, 16'd32767, 1'b0);
    frame("byp_hist", 16'd0, 16'd0, 32'h007B_FE38);

    // Mid-frame reset aborts the frame.
    @(negedge clk);
    audio_in = {16'd1000, 16'd1000};
    lrck     = 1'b1;
    @(posedge clk); #1;
    lrck = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_out",   audio_out, 32'h0);
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    check("mid_busy",  {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("mid_novalid", pulses, 32'd0);
    write_coef("mid_w1", 5'd1, 16'd32767, 1'b0);
    frame("mid_after", 16'd77, 16'hFFFB, 32'h004D_FFFB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
